cal_view_ctrl: RTL and testbench
================================

# cal_view_ctrl

Controller that selects which month the calendar page shows and computes that month's layout for the calendar renderer. It sequences user navigation (next, previous, today) and follows the live date automatically. For the displayed month it produces the month and year, the weekday of the 1st, the number of days, and the highlighted day. It sits between the date source and the calendar drawing path, in the pixel clock domain.

## Interface
- `YEAR_BASE`, default 2000: first supported year; 01-Jan of this year is a Saturday.
- `YEAR_MAX`, default 2999: last supported year.
- `BASE_WDAY`, default 5: weekday of 01-Jan-`YEAR_BASE` (0 = Mon … 6 = Sun).

Ports:
- `clk_i` in 1: pixel clock. This is the single clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `cur_day_i` in 5: live day, 1..31. Synchronous to `clk_i`.
- `cur_month_i` in 4: live month, 0 = Jan … 11 = Dec.
- `cur_year_i` in 12: live year, `YEAR_BASE`..`YEAR_MAX`.
- `next_i` in 1: one-cycle pulse; show the next month.
- `prev_i` in 1: one-cycle pulse; show the previous month.
- `today_i` in 1: one-cycle pulse; return to the live month.
- `view_month_o` out 4: displayed month.
- `view_year_o` out 12: displayed year.
- `month_first_day_o` out 3: weekday of the 1st, 0 = Mon.
- `month_days_cnt_o` out 5: 28..31.
- `day_in_month_o` out 5: day to highlight; 0 = none.
- `follow_o` out 1: view is tracking the live date.
- `busy_o` out 1: computation in progress.
- `upd_o` out 1: one-cycle pulse in the cycle the layout outputs change.

## Operation
- Reset values:
  - view = Jan/`YEAR_BASE`, first_day = 5, days_cnt = 31.
  - day_in_month = 0, busy = 0, upd = 0.
  - follow = 1.
  - A pending recompute flag is set to 1.
- FSM states: IDLE, LOAD, YEAR_STEP, MONTH_STEP, PUBLISH.
- IDLE accepts a command when a pulse is present or the pending flag is set. Priority: today > next/prev > follow-sync > pending.
  - next and prev together (without today): both ignored.
  - next/prev: target = view ±1 month. Dec→Jan increments the year; Jan→Dec decrements it.
  - At the range ends the command is ignored and no recompute happens. The ends are Dec/`YEAR_MAX` for next and Jan/`YEAR_BASE` for prev.
  - today: target = cur; sets follow = 1.
  - next/prev clears follow. follow is re-set at PUBLISH if the target equals (cur_month_i, cur_year_i).
  - follow-sync: if follow = 1 and (cur_month_i, cur_year_i) ≠ view, target = cur.
- LOAD: latch the target.
  - Clear the year counter to `YEAR_BASE` and the weekday accumulator to `BASE_WDAY`.
  - Clear the leap-tracking counters: mod-4, mod-100, mod-400.
- YEAR_STEP: one year per cycle while year counter < target year.
  - acc = (acc + (leap ? 2 : 1)) mod 7.
  - leap = (mod4 == 0 && mod100 != 0) || mod400 == 0.
  - All three counters advance with wrap.
  - No divider is used.
- MONTH_STEP: one month per cycle while month counter < target month.
  - acc = (acc + days(month, leap) mod 7) mod 7.
  - days: 31/28-or-29/31/30/31/30/31/31/30/31/30/31.
- PUBLISH: write view, first_day = acc, days_cnt = days(target, leap).
  - Update follow, pulse upd_o, return to IDLE.
  - Clear the pending flag.
- `day_in_month_o` is registered every cycle: `cur_day_i` if view == (cur_month_i, cur_year_i), else 0.
- Pulses arriving while busy_o = 1 are dropped; they are not queued.
- Live-date changes during busy are picked up by follow-sync after return to IDLE.
- Out-of-range cur_year_i: a today or follow-sync command is ignored.

## Timing
- busy_o rises the cycle after the command cycle (LOAD). It falls the cycle after PUBLISH.
- Latency from command cycle to upd_o: 2 + (Y − `YEAR_BASE`) + M cycles. Worst case is 2 + 999 + 11 = 1012 cycles.
- Layout outputs change only at PUBLISH and are held stable otherwise. Renderers may sample them at any time.
- day_in_month_o lags input changes by 1 cycle. It is recomputed against the new view in the cycle after PUBLISH.
- Reset asserted mid-computation returns all outputs to their reset values immediately. After release, the pending flag causes a recompute to the live date.

## Structure
- Package `cal_ctrl_pkg` contains:
  - the state enum;
  - `YEAR_BASE`/`YEAR_MAX`/`BASE_WDAY` defaults;
  - month-length function `days_in_month(month, leap)`;
  - weekday and month encodings.
- Sub-module `cal_wday_engine` implements LOAD through PUBLISH. It has a start/target/done handshake and returns first_day and days_cnt.
- The top level owns the command arbitration, the follow flag and the highlight register.

## Test plan
- Reset, then release with cur = 15/Jan/2000: after 2 cycles upd_o pulses; first_day = 5, days_cnt = 31, day_in_month = 15, follow = 1.
- Live date = 10/Feb/2024:
  - upd_o arrives 27 cycles after the command; first_day = 3, days_cnt = 29.
  - next: Mar/2024, first_day = 4, days_cnt = 31; follow = 0, day_in_month = 0.
- View Dec/2023, next: Jan/2024, first_day = 0.
- View Dec/2999, next: no upd_o, view unchanged.
- View Jan/2000, prev: ignored.
- Leap rule:
  - Feb/2100: days_cnt = 28.
  - Feb/2400: days_cnt = 29.
  - Feb/2000: days_cnt = 29.
- Simultaneous and dropped commands:
  - next+prev in the same cycle: ignored.
  - today+next: goes to the live month.
  - A pulse while busy: dropped.
  - With follow = 1, cur changes 31/Jan → 1/Feb: auto recompute, upd_o, day_in_month = 1.

Source files
------------

// File: rtl/cal_ctrl_pkg.sv
// cal_ctrl_pkg: shared definitions for the calendar view controller.
//   - Controller FSM state encoding.
//   - Default supported year range and weekday of 01-Jan of the base year.
//   - Weekday (0 = Mon .. 6 = Sun) and month (0 = Jan .. 11 = Dec) encodings.
//   - days_in_month(): month length lookup.
//   - add_mod7(): small modulo-7 adder for the weekday accumulator.
package cal_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_YEAR_STEP,
        ST_MONTH_STEP,
        ST_PUBLISH
    } cal_state_e;

    typedef enum logic [2:0] {
        WD_MON, WD_TUE, WD_WED, WD_THU, WD_FRI, WD_SAT, WD_SUN
    } wday_e;

    localparam logic [3:0] MONTH_JAN = 4'd0;
    localparam logic [3:0] MONTH_FEB = 4'd1;
    localparam logic [3:0] MONTH_APR = 4'd3;
    localparam logic [3:0] MONTH_JUN = 4'd5;
    localparam logic [3:0] MONTH_SEP = 4'd8;
    localparam logic [3:0] MONTH_NOV = 4'd10;
    localparam logic [3:0] MONTH_DEC = 4'd11;

    localparam int YEAR_BASE_DEF = 2000;
    localparam int YEAR_MAX_DEF  = 2999;
    localparam int BASE_WDAY_DEF = int'(WD_SAT);

    function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic leap);
        logic [4:0] d;
        case (month)
            MONTH_FEB: d = leap ? 5'd29 : 5'd28;
            MONTH_APR, MONTH_JUN, MONTH_SEP, MONTH_NOV: d = 5'd30;
            default: d = 5'd31;
        endcase
        return d;
    endfunction

    // acc is always 0..6 and inc 0..3, so a single conditional subtract wraps it.
    function automatic logic [2:0] add_mod7(input logic [2:0] acc, input logic [1:0] inc);
        logic [3:0] sum;
        sum = {1'b0, acc} + {2'b00, inc};
        return (sum >= 4'd7) ? 3'(sum - 4'd7) : sum[2:0];
    endfunction

endpackage

// File: rtl/cal_wday_engine.sv
// cal_wday_engine: computes the weekday of the 1st and the length of a target
// month by walking forward from 01-Jan of the base year, one year and then one
// month per cycle, using wrapping mod-4/100/400 counters instead of a divider.
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   start_i                   accepted only while idle; latches the target
//   tgt_month_i, tgt_year_i   month/year to compute
//   busy_o                    high from LOAD through PUBLISH
//   done_o                    high for the single PUBLISH cycle
//   tgt_month_o, tgt_year_o   latched target (valid while busy)
//   first_day_o, days_cnt_o   result, valid while done_o is high
module cal_wday_engine
    import cal_ctrl_pkg::*;
#(
    parameter int YEAR_BASE = YEAR_BASE_DEF,
    parameter int BASE_WDAY = BASE_WDAY_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [3:0]  tgt_month_i,
    input  logic [11:0] tgt_year_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [3:0]  tgt_month_o,
    output logic [11:0] tgt_year_o,
    output logic [2:0]  first_day_o,
    output logic [4:0]  days_cnt_o
);
    localparam logic [11:0] YEAR_BASE_L = 12'(YEAR_BASE);
    localparam logic [2:0]  BASE_WDAY_L = 3'(BASE_WDAY);

    cal_state_e  state_q, state_d;
    logic [3:0]  tgt_month_q, tgt_month_d;
    logic [11:0] tgt_year_q, tgt_year_d;
    logic [11:0] year_q, year_d;
    logic [3:0]  month_q, month_d;
    logic [2:0]  acc_q, acc_d;
    logic [1:0]  mod4_q, mod4_d;
    logic [6:0]  mod100_q, mod100_d;
    logic [8:0]  mod400_q, mod400_d;

    logic        leap;
    logic [4:0]  step_days;

    // The counters hold (year - YEAR_BASE) mod N; base year is a multiple of 400.
    assign leap      = ((mod4_q == 2'd0) && (mod100_q != 7'd0)) || (mod400_q == 9'd0);
    assign step_days = days_in_month(month_q, leap);

    always_comb begin
        state_d     = state_q;
        tgt_month_d = tgt_month_q;
        tgt_year_d  = tgt_year_q;
        year_d      = year_q;
        month_d     = month_q;
        acc_d       = acc_q;
        mod4_d      = mod4_q;
        mod100_d    = mod100_q;
        mod400_d    = mod400_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    tgt_month_d = tgt_month_i;
                    tgt_year_d  = tgt_year_i;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                year_d   = YEAR_BASE_L;
                month_d  = MONTH_JAN;
                acc_d    = BASE_WDAY_L;
                mod4_d   = 2'd0;
                mod100_d = 7'd0;
                mod400_d = 9'd0;
                // Zero-length phases are skipped so latency is exactly 2 + years + months.
                if (tgt_year_q != YEAR_BASE_L) begin
                    state_d = ST_YEAR_STEP;
                end else if (tgt_month_q != MONTH_JAN) begin
                    state_d = ST_MONTH_STEP;
                end else begin
                    state_d = ST_PUBLISH;
                end
            end
            ST_YEAR_STEP: begin
                // 365 = 1 mod 7, 366 = 2 mod 7.
                acc_d    = add_mod7(acc_q, leap ? 2'd2 : 2'd1);
                year_d   = year_q + 12'd1;
                mod4_d   = mod4_q + 2'd1;
                mod100_d = (mod100_q == 7'd99)  ? 7'd0 : mod100_q + 7'd1;
                mod400_d = (mod400_q == 9'd399) ? 9'd0 : mod400_q + 9'd1;
                if (year_d == tgt_year_q) begin
                    state_d = (tgt_month_q != MONTH_JAN) ? ST_MONTH_STEP : ST_PUBLISH;
                end
            end
            ST_MONTH_STEP: begin
                // Month lengths are 28..31, so (days - 28) is already days mod 7.
                acc_d   = add_mod7(acc_q, 2'(step_days - 5'd28));
                month_d = month_q + 4'd1;
                if (month_d == tgt_month_q) begin
                    state_d = ST_PUBLISH;
                end
            end
            ST_PUBLISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            tgt_month_q <= MONTH_JAN;
            tgt_year_q  <= YEAR_BASE_L;
            year_q      <= YEAR_BASE_L;
            month_q     <= MONTH_JAN;
            acc_q       <= BASE_WDAY_L;
            mod4_q      <= 2'd0;
            mod100_q    <= 7'd0;
            mod400_q    <= 9'd0;
        end else begin
            state_q     <= state_d;
            tgt_month_q <= tgt_month_d;
            tgt_year_q  <= tgt_year_d;
            year_q      <= year_d;
            month_q     <= month_d;
            acc_q       <= acc_d;
            mod4_q      <= mod4_d;
            mod100_q    <= mod100_d;
            mod400_q    <= mod400_d;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_PUBLISH);
    assign tgt_month_o = tgt_month_q;
    assign tgt_year_o  = tgt_year_q;
    assign first_day_o = acc_q;
    // After stepping, the leap counters sit on the target year.
    assign days_cnt_o  = days_in_month(tgt_month_q, leap);

endmodule

// File: rtl/cal_view_ctrl.sv
// cal_view_ctrl: chooses the month shown on the calendar page and exposes its
// layout to the renderer. Arbitrates today/next/prev pulses, live-date
// following and the post-reset recompute, drives cal_wday_engine, and holds
// the published layout plus the highlighted day.
// Ports:
//   clk_i, rst_i                         pixel clock, async active-high reset
//   cur_day_i, cur_month_i, cur_year_i   live date
//   next_i, prev_i, today_i              one-cycle navigation pulses
//   view_month_o, view_year_o            displayed month/year
//   month_first_day_o, month_days_cnt_o  weekday of the 1st, month length
//   day_in_month_o                       highlighted day, 0 = none
//   follow_o, busy_o, upd_o              tracking flag, engine busy, layout-change pulse
module cal_view_ctrl
    import cal_ctrl_pkg::*;
#(
    parameter int YEAR_BASE = YEAR_BASE_DEF,
    parameter int YEAR_MAX  = YEAR_MAX_DEF,
    parameter int BASE_WDAY = BASE_WDAY_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  cur_day_i,
    input  logic [3:0]  cur_month_i,
    input  logic [11:0] cur_year_i,
    input  logic        next_i,
    input  logic        prev_i,
    input  logic        today_i,
    output logic [3:0]  view_month_o,
    output logic [11:0] view_year_o,
    output logic [2:0]  month_first_day_o,
    output logic [4:0]  month_days_cnt_o,
    output logic [4:0]  day_in_month_o,
    output logic        follow_o,
    output logic        busy_o,
    output logic        upd_o
);
    localparam logic [11:0] YEAR_BASE_L = 12'(YEAR_BASE);
    localparam logic [11:0] YEAR_MAX_L  = 12'(YEAR_MAX);
    localparam logic [2:0]  BASE_WDAY_L = 3'(BASE_WDAY);

    logic [3:0]  view_month_q, view_month_d;
    logic [11:0] view_year_q, view_year_d;
    logic [2:0]  first_day_q, first_day_d;
    logic [4:0]  days_cnt_q, days_cnt_d;
    logic        follow_q, follow_d;
    logic        pending_q, pending_d;
    logic [4:0]  day_q, day_d;

    logic        eng_busy, eng_done;
    logic [3:0]  eng_month;
    logic [11:0] eng_year;
    logic [2:0]  eng_first;
    logic [4:0]  eng_days;

    logic        cmd_start;
    logic [3:0]  cmd_month;
    logic [11:0] cmd_year;
    logic        cur_valid, cur_is_view, at_last, at_first;

    assign cur_valid   = (cur_year_i >= YEAR_BASE_L) && (cur_year_i <= YEAR_MAX_L) &&
                         (cur_month_i <= MONTH_DEC);
    assign cur_is_view = (cur_month_i == view_month_q) && (cur_year_i == view_year_q);
    assign at_last     = (view_month_q == MONTH_DEC) && (view_year_q == YEAR_MAX_L);
    assign at_first    = (view_month_q == MONTH_JAN) && (view_year_q == YEAR_BASE_L);

    always_comb begin
        cmd_start    = 1'b0;
        cmd_month    = view_month_q;
        cmd_year     = view_year_q;
        view_month_d = view_month_q;
        view_year_d  = view_year_q;
        first_day_d  = first_day_q;
        days_cnt_d   = days_cnt_q;
        follow_d     = follow_q;
        pending_d    = pending_q;

        // Pulses are only looked at while the engine is idle; otherwise dropped.
        if (!eng_busy) begin
            if (today_i) begin
                if (cur_valid) begin
                    cmd_start = 1'b1;
                    cmd_month = cur_month_i;
                    cmd_year  = cur_year_i;
                    follow_d  = 1'b1;
                end
            end else if (next_i && !prev_i) begin
                if (!at_last) begin
                    cmd_start = 1'b1;
                    cmd_month = (view_month_q == MONTH_DEC) ? MONTH_JAN : view_month_q + 4'd1;
                    cmd_year  = (view_month_q == MONTH_DEC) ? view_year_q + 12'd1 : view_year_q;
                    follow_d  = 1'b0;
                end
            end else if (prev_i && !next_i) begin
                if (!at_first) begin
                    cmd_start = 1'b1;
                    cmd_month = (view_month_q == MONTH_JAN) ? MONTH_DEC : view_month_q - 4'd1;
                    cmd_year  = (view_month_q == MONTH_JAN) ? view_year_q - 12'd1 : view_year_q;
                    follow_d  = 1'b0;
                end
            end else if (follow_q && !cur_is_view && cur_valid) begin
                cmd_start = 1'b1;
                cmd_month = cur_month_i;
                cmd_year  = cur_year_i;
            end else if (pending_q) begin
                // With no usable live date, refresh the current view instead.
                cmd_start = 1'b1;
                if (cur_valid) begin
                    cmd_month = cur_month_i;
                    cmd_year  = cur_year_i;
                end
            end
        end

        if (eng_done) begin
            view_month_d = eng_month;
            view_year_d  = eng_year;
            first_day_d  = eng_first;
            days_cnt_d   = eng_days;
            follow_d     = follow_q || ((eng_month == cur_month_i) && (eng_year == cur_year_i));
            pending_d    = 1'b0;
        end
    end

    cal_wday_engine #(
        .YEAR_BASE (YEAR_BASE),
        .BASE_WDAY (BASE_WDAY)
    ) u_engine (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (cmd_start),
        .tgt_month_i (cmd_month),
        .tgt_year_i  (cmd_year),
        .busy_o      (eng_busy),
        .done_o      (eng_done),
        .tgt_month_o (eng_month),
        .tgt_year_o  (eng_year),
        .first_day_o (eng_first),
        .days_cnt_o  (eng_days)
    );

    // The layout is presented straight from the engine during PUBLISH so it
    // changes in the same cycle as upd_o, then is held from the registers.
    assign view_month_o      = eng_done ? eng_month : view_month_q;
    assign view_year_o       = eng_done ? eng_year  : view_year_q;
    assign month_first_day_o = eng_done ? eng_first : first_day_q;
    assign month_days_cnt_o  = eng_done ? eng_days  : days_cnt_q;

    assign day_d = ((view_month_o == cur_month_i) && (view_year_o == cur_year_i)) ? cur_day_i : 5'd0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            view_month_q <= MONTH_JAN;
            view_year_q  <= YEAR_BASE_L;
            first_day_q  <= BASE_WDAY_L;
            days_cnt_q   <= 5'd31;
            follow_q     <= 1'b1;
            pending_q    <= 1'b1;
            day_q        <= 5'd0;
        end else begin
            view_month_q <= view_month_d;
            view_year_q  <= view_year_d;
            first_day_q  <= first_day_d;
            days_cnt_q   <= days_cnt_d;
            follow_q     <= follow_d;
            pending_q    <= pending_d;
            day_q        <= day_d;
        end
    end

    assign day_in_month_o = day_q;
    assign follow_o       = follow_q;
    assign busy_o         = eng_busy;
    assign upd_o          = eng_done;

endmodule

// File: tb/tb_cal_view_ctrl.sv
// tb_cal_view_ctrl: directed navigation scenarios for cal_view_ctrl with a
// calendar model (day counting from 01-Jan-2000) and a per-cycle compare process.
module tb_cal_view_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  cur_day;
    logic [3:0]  cur_month;
    logic [11:0] cur_year;
    logic        next_p, prev_p, today_p;
    logic [3:0]  view_month;
    logic [11:0] view_year;
    logic [2:0]  first_day;
    logic [4:0]  days_cnt;
    logic [4:0]  dim;
    logic        follow, busy, upd;

    int chk_cnt = 0;
    int err_cnt = 0;

    // Model state: what the page must show, as set by the scenario.
    int exp_month, exp_year, exp_first, exp_days, exp_follow, exp_dim;
    bit in_cmd     = 1'b0;
    bit prev_valid = 1'b0;

    always #5 clk = ~clk;

    cal_view_ctrl dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .cur_day_i         (cur_day),
        .cur_month_i       (cur_month),
        .cur_year_i        (cur_year),
        .next_i            (next_p),
        .prev_i            (prev_p),
        .today_i           (today_p),
        .view_month_o      (view_month),
        .view_year_o       (view_year),
        .month_first_day_o (first_day),
        .month_days_cnt_o  (days_cnt),
        .day_in_month_o    (dim),
        .follow_o          (follow),
        .busy_o            (busy),
        .upd_o             (upd)
    );

    function automatic bit m_leap(input int y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    endfunction

    function automatic int m_days(input int m, input int y);
        if (m == 1) return m_leap(y) ? 29 : 28;
        if (m == 3 || m == 5 || m == 8 || m == 10) return 30;
        return 31;
    endfunction

    // Weekday of the 1st: total days elapsed since Saturday 01-Jan-2000.
    function automatic int m_wday(input int m, input int y);
        int d;
        d = 0;
        for (int yy = 2000; yy < y; yy++) d += m_leap(yy) ? 366 : 365;
        for (int mm = 0; mm < m; mm++) d += m_days(mm, y);
        return (5 + d) % 7;
    endfunction

    task automatic check(input string name, input int act, input int req);
        chk_cnt++;
        if (act != req) begin
            err_cnt++;
            if (err_cnt <= 30) $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic set_exp(input int m, input int y);
        exp_month = m;
        exp_year  = y;
        exp_first = m_wday(m, y);
        exp_days  = m_days(m, y);
    endtask

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("view_month", int'(view_month), exp_month);
            check("view_year",  int'(view_year),  exp_year);
            check("first_day",  int'(first_day),  exp_first);
            check("days_cnt",   int'(days_cnt),   exp_days);
            if (rst) begin
                check("rst_dim",    int'(dim),    0);
                check("rst_busy",   int'(busy),   0);
                check("rst_upd",    int'(upd),    0);
                check("rst_follow", int'(follow), 1);
                prev_valid = 1'b0;
            end else begin
                if (!in_cmd) check("follow", int'(follow), exp_follow);
                if (prev_valid) check("day_in_month", int'(dim), exp_dim);
                exp_dim = (exp_month == int'(cur_month) && exp_year == int'(cur_year)) ? int'(cur_day) : 0;
                prev_valid = 1'b1;
            end
        end
    end

    task automatic cmd(input logic n, input logic p, input logic t);
        @(posedge clk); #1;
        next_p = n; prev_p = p; today_p = t;
    endtask

    task automatic set_cur(input int d, input int m, input int y);
        @(posedge clk); #1;
        cur_day = 5'(d); cur_month = 4'(m); cur_year = 12'(y);
    endtask

    // Wait for upd_o counting cycles from the command cycle; optionally fire a
    // prev pulse at cycle drop_at (must be dropped by the busy DUT).
    task automatic wait_upd(input int lat, input int drop_at, input int tm, input int ty,
                            input int tf, input string name);
        int cyc;
        bit seen;
        in_cmd = 1'b1;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 1100) begin
            @(posedge clk); #1;
            next_p = 1'b0; prev_p = 1'b0; today_p = 1'b0;
            cyc++;
            if (cyc == drop_at) prev_p = 1'b1;
            if (upd) seen = 1'b1;
        end
        check({name, "_latency"}, seen ? cyc : -1, lat);
        set_exp(tm, ty);
        exp_follow = tf;
        $display("txn %s: view %0d/%0d first_day %0d days %0d latency %0d",
                 name, view_month, view_year, first_day, days_cnt, cyc);
        @(posedge clk); #1;
        in_cmd = 1'b0;
    endtask

    task automatic expect_quiet(input int ncyc, input string name);
        int seen;
        seen = 0;
        repeat (ncyc) begin
            @(posedge clk); #1;
            next_p = 1'b0; prev_p = 1'b0; today_p = 1'b0;
            if (upd || busy) seen++;
        end
        check({name, "_no_activity"}, seen, 0);
        $display("txn %s: view %0d/%0d unchanged", name, view_month, view_year);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cur_day = 5'd15; cur_month = 4'd0; cur_year = 12'd2000;
        next_p = 1'b0; prev_p = 1'b0; today_p = 1'b0;
        set_exp(0, 2000);
        exp_follow = 1;
        exp_dim = 0;
        rst = 1'b1;

        // Pin the model against hand-computed dates.
        check("pin_wday_feb2024", m_wday(1, 2024), 3);
        check("pin_wday_jan2024", m_wday(0, 2024), 0);
        check("pin_wday_jan2000", m_wday(0, 2000), 5);
        check("pin_days_feb2100", m_days(1, 2100), 28);
        check("pin_days_feb2400", m_days(1, 2400), 29);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_upd(2, 0, 0, 2000, 1, "reset_release");
        check("rst_first_day", int'(first_day), 5);
        check("rst_days", int'(days_cnt), 31);
        check("rst_dim15", int'(dim), 15);

        set_cur(10, 1, 2024);
        wait_upd(27, 0, 1, 2024, 1, "follow_feb2024");
        check("feb2024_first", int'(first_day), 3);
        check("feb2024_days", int'(days_cnt), 29);
        check("feb2024_dim", int'(dim), 10);

        cmd(1'b1, 1'b0, 1'b0);
        wait_upd(28, 0, 2, 2024, 0, "next_mar2024");
        check("mar2024_first", int'(first_day), 4);
        check("mar2024_days", int'(days_cnt), 31);
        check("mar2024_follow", int'(follow), 0);
        check("mar2024_dim", int'(dim), 0);

        cmd(1'b0, 1'b0, 1'b1);
        wait_upd(27, 0, 1, 2024, 1, "today_feb2024");

        set_cur(20, 11, 2023);
        wait_upd(36, 0, 11, 2023, 1, "follow_dec2023");
        cmd(1'b1, 1'b0, 1'b0);
        wait_upd(26, 0, 0, 2024, 0, "next_jan2024");
        check("jan2024_first", int'(first_day), 0);
        check("jan2024_year", int'(view_year), 2024);

        cmd(1'b1, 1'b1, 1'b0);
        expect_quiet(40, "next_prev_same_cycle");

        cmd(1'b1, 1'b0, 1'b1);
        wait_upd(36, 0, 11, 2023, 1, "today_plus_next");
        check("today_next_month", int'(view_month), 11);

        set_cur(10, 1, 2100);
        wait_upd(103, 0, 1, 2100, 1, "feb2100");
        check("feb2100_days", int'(days_cnt), 28);
        set_cur(10, 1, 2400);
        wait_upd(403, 0, 1, 2400, 1, "feb2400");
        check("feb2400_days", int'(days_cnt), 29);
        set_cur(10, 1, 2000);
        wait_upd(3, 0, 1, 2000, 1, "feb2000");
        check("feb2000_days", int'(days_cnt), 29);

        set_cur(31, 11, 2999);
        wait_upd(1012, 0, 11, 2999, 1, "dec2999");
        cmd(1'b1, 1'b0, 1'b0);
        expect_quiet(20, "next_at_dec2999");
        check("dec2999_year", int'(view_year), 2999);

        set_cur(1, 0, 2000);
        wait_upd(2, 0, 0, 2000, 1, "jan2000");
        cmd(1'b0, 1'b1, 1'b0);
        expect_quiet(20, "prev_at_jan2000");

        set_cur(5, 5, 2500);
        wait_upd(507, 5, 5, 2500, 1, "busy_drop_jun2500");
        expect_quiet(20, "dropped_prev");

        set_cur(31, 0, 2001);
        wait_upd(3, 0, 0, 2001, 1, "jan2001");
        check("jan2001_dim", int'(dim), 31);
        set_cur(1, 1, 2001);
        wait_upd(4, 0, 1, 2001, 1, "rollover_feb2001");
        check("feb2001_dim", int'(dim), 1);

        set_cur(5, 5, 2700);
        in_cmd = 1'b1;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        set_exp(0, 2000);
        exp_follow = 1;
        #1;
        check("midrst_year", int'(view_year), 2000);
        check("midrst_busy", int'(busy), 0);
        check("midrst_first", int'(first_day), 5);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_upd(707, 0, 5, 2700, 1, "after_reset_jun2700");
        check("jun2700_dim", int'(dim), 5);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
